// File: rtl/m68k_bus_master.sv
// 68000-style bus cycle initiator: turns a req/ack transaction into an
// AS/UDS/LDS/RW cycle terminated by DTACK, with a DTACK timeout.
//
// Handshake: req is sampled only in IDLE when the synchronised DTACK is
// released. The requester holds req (and addr/we/be/wdata) until busy is seen
// high. busy stays high until the cycle after the one-cycle ack pulse.
// err and rdata are valid in the ack cycle. A req seen while busy is dropped.
module m68k_bus_master #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        sysclk,
    input  logic        sysrst,
    input  logic        req,
    input  logic        we,
    input  logic [22:0] addr,
    input  logic [1:0]  be,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        ack,
    output logic        err,
    output logic [15:0] rdata,
    output logic [22:0] bus_addr,
    output logic [15:0] bus_dout,
    output logic        bus_doe,
    input  logic [15:0] bus_din,
    output logic        as_n,
    output logic        uds_n,
    output logic        lds_n,
    output logic        rw,
    input  logic        dtack_n,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_ASSERT = 3'd2,
        S_WAIT   = 3'd3,
        S_LATCH  = 3'd4,
        S_END    = 3'd5,
        S_HOLD   = 3'd6
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        hit_q, hit_d;
    logic        we_q, we_d;
    logic [1:0]  be_q, be_d;
    logic [22:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        err_pend_q, err_pend_d;
    logic [15:0] rdata_q, rdata_d;
    logic        dt_meta_q, dt_sync_q;
    logic        as_n_q, as_n_d;
    logic        uds_n_q, uds_n_d;
    logic        lds_n_q, lds_n_d;
    logic        rw_q, rw_d;
    logic        doe_q, doe_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic        in_cycle;
    logic        strobe_on;

    // Two-flop synchroniser for the asynchronous DTACK input.
    always_ff @(posedge sysclk or posedge sysrst) begin
        if (sysrst) begin
            dt_meta_q <= 1'b1;
            dt_sync_q <= 1'b1;
        end else begin
            dt_meta_q <= dtack_n;
            dt_sync_q <= dt_meta_q;
        end
    end

    // Next-state, transaction capture, timeout counter and read data.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hit_d      = hit_q;
        we_d       = we_q;
        be_d       = be_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_pend_d = err_pend_q;
        rdata_d    = rdata_q;
        case (state_q)
            S_IDLE: begin
                cnt_d      = 8'd0;
                hit_d      = 1'b0;
                err_pend_d = 1'b0;
                if (req && dt_sync_q) begin
                    state_d = S_ADDR;
                    we_d    = we;
                    be_d    = (be == 2'b00) ? 2'b11 : be;
                    addr_d  = addr;
                    wdata_d = wdata;
                end
            end
            S_ADDR:   state_d = S_ASSERT;
            S_ASSERT: state_d = S_WAIT;
            S_WAIT: begin
                // The terminal-count compare is registered (hit_q), so the
                // abort lands one cycle after the counter reads TIMEOUT-1.
                if (!hit_q) cnt_d = cnt_q + 8'd1;
                hit_d = hit_q | (cnt_q == TO_LAST);
                if (!dt_sync_q) begin
                    state_d = S_LATCH;
                end else if (hit_q) begin
                    state_d    = S_END;
                    err_pend_d = 1'b1;
                end
            end
            S_LATCH: begin
                if (!we_q) begin
                    rdata_d = {be_q[1] ? bus_din[15:8] : 8'h00,
                               be_q[0] ? bus_din[7:0]  : 8'h00};
                end
                state_d = S_END;
            end
            S_END: begin
                if (err_pend_q) rdata_d = 16'hFFFF;
                state_d = S_HOLD;
            end
            S_HOLD:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus and handshake outputs decoded from the next state, then registered.
    always_comb begin
        in_cycle  = (state_d inside {S_ADDR, S_ASSERT, S_WAIT, S_LATCH, S_END});
        strobe_on = (state_d inside {S_WAIT, S_LATCH}) || ((state_d == S_ASSERT) && !we_d);
        as_n_d    = !(state_d inside {S_ASSERT, S_WAIT, S_LATCH});
        uds_n_d   = !(strobe_on && be_d[1]);
        lds_n_d   = !(strobe_on && be_d[0]);
        rw_d      = in_cycle ? !we_d : 1'b1;
        doe_d     = in_cycle && we_d;
        ack_d     = (state_d == S_HOLD);
        err_d     = (state_d == S_HOLD) && err_pend_d;
        busy_d    = (state_d != S_IDLE);
    end

    // State and output registers; reset releases strobes immediately.
    always_ff @(posedge sysclk or posedge sysrst) begin
        if (sysrst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            hit_q      <= 1'b0;
            we_q       <= 1'b0;
            be_q       <= 2'b00;
            addr_q     <= 23'd0;
            wdata_q    <= 16'd0;
            err_pend_q <= 1'b0;
            rdata_q    <= 16'd0;
            as_n_q     <= 1'b1;
            uds_n_q    <= 1'b1;
            lds_n_q    <= 1'b1;
            rw_q       <= 1'b1;
            doe_q      <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hit_q      <= hit_d;
            we_q       <= we_d;
            be_q       <= be_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_pend_q <= err_pend_d;
            rdata_q    <= rdata_d;
            as_n_q     <= as_n_d;
            uds_n_q    <= uds_n_d;
            lds_n_q    <= lds_n_d;
            rw_q       <= rw_d;
            doe_q      <= doe_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign ack       = ack_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign bus_addr  = addr_q;
    assign bus_dout  = wdata_q;
    assign bus_doe   = doe_q;
    assign as_n      = as_n_q;
    assign uds_n     = uds_n_q;
    assign lds_n     = lds_n_q;
    assign rw        = rw_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_m68k_bus_master.sv
// Bench for m68k_bus_master: directed bus cycles with a responder model,
// an expected-response queue checked by an ack monitor, and per-cycle
// strobe checks relative to the accept edge.
module tb_m68k_bus_master;

    localparam int TO = 8;

    logic        sysclk;
    logic        sysrst;
    logic        req;
    logic        we;
    logic [22:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
    logic        busy;
    logic        ack;
    logic        err;
    logic [15:0] rdata;
    logic [22:0] bus_addr;
    logic [15:0] bus_dout;
    logic        bus_doe;
    logic [15:0] bus_din;
    logic        as_n;
    logic        uds_n;
    logic        lds_n;
    logic        rw;
    logic        dtack_n;
    logic [2:0]  dbg_state;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [16:0] exp_q[$];

    m68k_bus_master #(.TIMEOUT(TO)) dut (
        .sysclk    (sysclk),
        .sysrst    (sysrst),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .be        (be),
        .wdata     (wdata),
        .busy      (busy),
        .ack       (ack),
        .err       (err),
        .rdata     (rdata),
        .bus_addr  (bus_addr),
        .bus_dout  (bus_dout),
        .bus_doe   (bus_doe),
        .bus_din   (bus_din),
        .as_n      (as_n),
        .uds_n     (uds_n),
        .lds_n     (lds_n),
        .rw        (rw),
        .dtack_n   (dtack_n),
        .dbg_state (dbg_state)
    );

    // Clock and cycle counter
    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog act=running req=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected {as_n,uds_n,lds_n,bus_doe,rw} at cycle r after accept, ack at a.
    function automatic logic [4:0] exp_bus(input int r, input int a, input logic w, input logic [1:0] b);
        logic as_low, st, in_cyc;
        as_low = (r >= 2) && (r <= a - 2);
        st     = ((r >= 3) && (r <= a - 2)) || ((r == 2) && !w);
        in_cyc = (r >= 1) && (r <= a - 1);
        return {!as_low, !(st && b[1]), !(st && b[0]), w && in_cyc, in_cyc ? !w : 1'b1};
    endfunction

    // Monitor: every ack pops one expected {err, rdata}
    always begin
        @(posedge sysclk);
        #1;
        if (ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                check("ack_err", {31'd0, err}, {31'd0, e[16]});
                check("ack_rdata", {16'd0, rdata}, {16'd0, e[15:0]});
            end
        end
    end

    // One bus cycle. dt: cycle after accept at which the responder pulls
    // dtack_n low (-1 = never). stuck: dtack_n held low for this many cycles
    // after req rises (0 = not stuck).
    task automatic do_cycle(input logic w, input logic [22:0] a, input logic [1:0] b,
                            input logic [15:0] wd, input logic [15:0] din,
                            input int dt, input int stuck, input logic [15:0] exp_rd);
        int exp_a, start, base, r, n;
        logic [1:0] beff;
        logic [4:0] rec[64];
        logic done;
        exp_a = (dt < 0) ? TO + 5 : dt + 5;
        beff  = (b == 2'b00) ? 2'b11 : b;
        @(posedge sysclk); #1;
        if (stuck > 0) begin
            dtack_n = 1'b0;
            repeat (3) begin @(posedge sysclk); #1; end
        end
        req = 1'b1; we = w; addr = a; be = b; wdata = wd; bus_din = din;
        exp_q.push_back({(dt < 0), exp_rd});
        start = cyc;
        n = 0;
        while (!busy && n < 40) begin
            if (stuck > 0 && cyc - start == stuck) dtack_n = 1'b1;
            @(posedge sysclk); #1;
            n++;
        end
        if (!busy) begin
            check("accept", 32'd0, 32'd1);
            req = 1'b0;
            dtack_n = 1'b1;
            void'(exp_q.pop_back());
            return;
        end
        base = cyc - 1;
        req  = 1'b0;
        check("accept_cycle", base - start, (stuck > 0) ? stuck + 2 : 0);
        done = 1'b0;
        r = 1;
        while (!done) begin
            r = cyc - base;
            if (r < 64) rec[r] = {as_n, uds_n, lds_n, bus_doe, rw};
            if (r == dt) dtack_n = 1'b0;
            if (dt >= 1 && r > dt + 1 && as_n) dtack_n = 1'b1;
            if (ack) done = 1'b1;
            else if (r >= 60) begin
                check("ack_timeout", 32'd0, 32'd1);
                done = 1'b1;
            end else begin
                @(posedge sysclk); #1;
            end
        end
        check("ack_cycle", r, exp_a);
        for (int rr = 1; rr <= r && rr < 64; rr++)
            check($sformatf("bus_c%0d", rr), {27'd0, rec[rr]}, {27'd0, exp_bus(rr, exp_a, w, beff)});
        @(posedge sysclk); #1;
        dtack_n = 1'b1;
        check("busy_after_ack", {31'd0, busy}, 32'd0);
    endtask

    // Write cycle interrupted by reset during WAIT; no ack may follow.
    task automatic reset_mid_cycle();
        int n, acks;
        @(posedge sysclk); #1;
        req = 1'b1; we = 1'b1; addr = 23'h055555; be = 2'b11; wdata = 16'h9999;
        n = 0;
        while (!busy && n < 20) begin @(posedge sysclk); #1; n++; end
        req = 1'b0;
        repeat (4) begin @(posedge sysclk); #1; end
        check("pre_rst_as_low", {31'd0, as_n}, 32'd0);
        sysrst = 1'b1;
        #1;
        check("rst_strobes", {29'd0, as_n, uds_n, lds_n}, 32'h7);
        check("rst_doe", {31'd0, bus_doe}, 32'd0);
        check("rst_busy_rw", {30'd0, busy, rw}, 32'h1);
        @(posedge sysclk); #1;
        sysrst = 1'b0;
        check("rst_rdata", {16'd0, rdata}, 32'd0);
        check("rst_bus_addr", {9'd0, bus_addr}, 32'd0);
        acks = 0;
        repeat (20) begin
            @(posedge sysclk); #1;
            if (ack) acks++;
        end
        check("no_ack_after_rst", acks, 32'd0);
    endtask

    initial begin
        sysrst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
        bus_din = '0; dtack_n = 1'b1;
        repeat (3) @(posedge sysclk);
        #1;
        check("reset_strobes", {28'd0, as_n, uds_n, lds_n, rw}, 32'hF);
        check("reset_ctl", {28'd0, bus_doe, busy, ack, err}, 32'd0);
        check("reset_rdata", {16'd0, rdata}, 32'd0);
        check("reset_bus", {9'd0, bus_addr} | {16'd0, bus_dout}, 32'd0);
        check("reset_state", {29'd0, dbg_state}, 32'd0);
        sysrst = 1'b0;

        do_cycle(1'b0, 23'h400000, 2'b11, 16'h0000, 16'hBEEF, 1, 0, 16'hBEEF);
        do_cycle(1'b1, 23'h000123, 2'b10, 16'h12AB, 16'h0000, 7, 0, 16'hBEEF);
        check("write_bus_dout", {16'd0, bus_dout}, 32'h12AB);
        check("write_bus_addr", {9'd0, bus_addr}, 32'h000123);
        do_cycle(1'b0, 23'h7FFFFF, 2'b11, 16'h0000, 16'h5555, -1, 0, 16'hFFFF);
        do_cycle(1'b0, 23'h000010, 2'b01, 16'h0000, 16'hA55A, 1, 0, 16'h005A);
        do_cycle(1'b0, 23'h000011, 2'b10, 16'h0000, 16'hA55A, 2, 0, 16'hA500);
        do_cycle(1'b0, 23'h000012, 2'b00, 16'h0000, 16'h1234, 1, 0, 16'h1234);
        do_cycle(1'b0, 23'h200000, 2'b11, 16'h0000, 16'hC0DE, 1, 4, 16'hC0DE);
        reset_mid_cycle();
        do_cycle(1'b0, 23'h400002, 2'b11, 16'h0000, 16'h4321, 1, 0, 16'h4321);

        repeat (3) @(posedge sysclk);
        #2;
        check("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
